snake_game_ctrl: RTL and testbench
==================================

// Module: snake_game_ctrl
// PURPOSE
//  Game sequencer between the PS/2 direction decoder, the snake/apple pixel datapath and the score/LED outputs.
//  Accumulates per-pixel hit flags over each update period and filters direction keys.
//  Decides once per update tick: move, eat, lose or win. Raises one-shot move and apple-respawn handshakes.
//  Ensures exactly one score increment per apple eaten.
// PARAMETERS
//  BASE_STEP  4   pixels per move at score 0
//  WIN_COUNT  16  apples needed to win; must fit in CNT_W
//  CNT_W      5   width of apple_count
// PORTS
//  clk          in   1      single clock (VGA 25 MHz domain); all logic on posedge
//  rst          in   1      synchronous, active-high reset
//  tick_en      in   1      1-cycle strobe per game update (~25 Hz)
//  dir_in       in   4      one-hot key: 0001 up, 0010 left, 0100 down, 1000 right, 0000 none
//  hit_apple    in   1      head pixel overlaps apple pixel this cycle
//  hit_body     in   1      head pixel overlaps body segment 3..15 this cycle
//  hit_border   in   1      head pixel overlaps border this cycle
//  spawn_ack    in   1      apple placer has loaded a new position
//  move_en      out  1      1-cycle pulse: advance head by step_size along dir_out, shift body
//  dir_out      out  4      latched one-hot heading
//  step_size    out  5      BASE_STEP + apple_count/2
//  apple_count  out  CNT_W  score; also selects visible segments
//  spawn_req    out  1      request new apple position; held until spawn_ack
//  game_over    out  1      level: lost
//  win          out  1      level: won
// BEHAVIOUR
//  Reset values: move_en=0, dir_out=0000, step_size=BASE_STEP, apple_count=0, spawn_req=0, game_over=0, win=0.
//  Reset sets state=IDLE and clears the sticky flags. Reset in any state, mid-handshake included, takes effect next edge.
//  States: IDLE, RUN, OVER, WIN (+ PAUSE, see CONFIGURATION).
//  IDLE: on a valid one-hot dir_in, latch dir_out and go to RUN. Ticks are ignored and no move_en fires.
//  Direction filter, RUN only:
//    - non-one-hot or 0000 is ignored;
//    - the exact reverse of dir_out is ignored;
//    - otherwise dir_out updates on the next edge.
//  Sticky flags s_apple/s_body/s_border OR in the hit_* inputs every cycle in RUN.
//  Sticky flags clear on the cycle move_en is asserted.
//  s_apple does not accumulate while spawn_req=1 (stale apple).
//  On tick_en in RUN, the decision takes effect one cycle later, in priority order:
//    1. s_body|s_border -> OVER, game_over=1, no move_en.
//    2. s_apple and apple_count+1==WIN_COUNT -> apple_count++, WIN, win=1, no move_en.
//    3. s_apple -> apple_count++, spawn_req=1, move_en=1.
//    4. else -> move_en=1.
//  Simultaneous apple and border/body hits: case 1 wins, score unchanged.
//  step_size is registered from the updated apple_count, effective for the next move.
//  Width: count/2 is a shift; sum fits 5 bits for WIN_COUNT<=16.
//  spawn_req: set per case 3, drops the cycle after spawn_ack=1.
//  spawn_ack while spawn_req=0 is ignored. No second increment is possible until ack.
//  OVER and WIN are terminal until rst. All inputs are ignored there and outputs hold.
// CONFIGURATION
//  SNAKE_CTRL_PAUSE_EN defined:
//    - adds input pause_key (1 bit, level); a rising edge toggles RUN<->PAUSE;
//    - in PAUSE, ticks, hits and dir_in are ignored and sticky flags hold.
//  Undefined: no pause_key port and no PAUSE state; behaviour otherwise identical.
// STRUCTURE
//  snake_pkg.sv holds:
//    - DIR_UP/LEFT/DOWN/RIGHT one-hot constants;
//    - the ctrl_state_t enum {IDLE,RUN,OVER,WIN,PAUSE};
//    - the function dir_reverse().
//  Sub-module snake_dir_filter: one-hot check plus reversal block. Combinational accept, registered dir_out.
//  The FSM, sticky flags, score counter and spawn handshake live in snake_game_ctrl.
// TESTING
//  1. rst, dir_in=1000, 3 ticks, no hits -> exactly 3 move_en pulses, dir_out=1000, step_size=4.
//  2. RUN heading 1000; dir_in=0010 then 0001 -> 0010 ignored, dir_out=0001.
//  3. hit_apple held 50 cycles before tick, spawn_ack 10 cycles later:
//     - apple_count 0->1 once, spawn_req high 10 cycles;
//     - a second tick before ack gives no increment;
//     - step_size=4 (count 2 -> 5).
//  4. hit_apple and hit_border in same window, then tick -> game_over=1, apple_count unchanged, no move_en.
//  5. apple_count=15, apple hit, tick -> apple_count=16, win=1, spawn_req=0. rst -> all outputs at reset values.
//  6. rst asserted while spawn_req=1 -> next edge spawn_req=0, state IDLE; later spawn_ack ignored.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared constants, controller state type and heading helpers for the snake game.
package snake_pkg;

    localparam int unsigned DIR_W = 4;

    localparam logic [DIR_W-1:0] DIR_UP    = 4'b0001;
    localparam logic [DIR_W-1:0] DIR_LEFT  = 4'b0010;
    localparam logic [DIR_W-1:0] DIR_DOWN  = 4'b0100;
    localparam logic [DIR_W-1:0] DIR_RIGHT = 4'b1000;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        OVER  = 3'd2,
        WIN   = 3'd3,
        PAUSE = 3'd4
    } ctrl_state_t;

    // Opposite heading: up<->down and left<->right are two bit positions apart.
    function automatic logic [DIR_W-1:0] dir_reverse(input logic [DIR_W-1:0] d);
        return {d[1:0], d[3:2]};
    endfunction

endpackage

// File: rtl/snake_dir_filter.sv
// Direction key filter: accepts one-hot keys that do not reverse the current heading.
module snake_dir_filter
    import snake_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIR_W-1:0] dir_in,
    output logic [DIR_W-1:0] dir_out,
    output logic             accept_c
);

    logic [DIR_W-1:0] dir_q;
    logic [DIR_W-1:0] dir_d;
    logic             onehot_c;

    // Accept a single-bit key that is not the exact reverse of the held heading.
    always_comb begin
        onehot_c = (dir_in != '0) && ((dir_in & (dir_in - DIR_W'(1))) == '0);
        accept_c = en && onehot_c && (dir_in != dir_reverse(dir_q));
        dir_d    = accept_c ? dir_in : dir_q;
    end

    // Heading register.
    always_ff @(posedge clk) begin
        if (rst) begin
            dir_q <= '0;
        end else begin
            dir_q <= dir_d;
        end
    end

    assign dir_out = dir_q;

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: hit accumulation, per-tick move/eat/lose/win decision,
// score counter and apple-respawn handshake.
// Optional feature: define SNAKE_CTRL_PAUSE_EN to add the pause_key input and PAUSE state.
module snake_game_ctrl
    import snake_pkg::*;
#(
    parameter int unsigned BASE_STEP = 4,
    parameter int unsigned WIN_COUNT = 16,
    parameter int unsigned CNT_W     = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_en,
    input  logic [DIR_W-1:0] dir_in,
    input  logic             hit_apple,
    input  logic             hit_body,
    input  logic             hit_border,
    input  logic             spawn_ack,
`ifdef SNAKE_CTRL_PAUSE_EN
    input  logic             pause_key,
`endif
    output logic             move_en,
    output logic [DIR_W-1:0] dir_out,
    output logic [4:0]       step_size,
    output logic [CNT_W-1:0] apple_count,
    output logic             spawn_req,
    output logic             game_over,
    output logic             win
);

    localparam int unsigned STEP_W = 5;

    ctrl_state_t       state_q, state_d;
    logic              move_en_q, move_en_d;
    logic [STEP_W-1:0] step_size_q, step_size_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              spawn_req_q, spawn_req_d;
    logic              game_over_q, game_over_d;
    logic              win_q, win_d;
    logic              s_apple_q, s_apple_d;
    logic              s_body_q, s_body_d;
    logic              s_border_q, s_border_d;
    logic              dir_accept_c;
    logic              dir_en_c;
    logic              pause_rise_c;

`ifdef SNAKE_CTRL_PAUSE_EN
    logic pause_key_q, pause_key_d;

    // Previous pause_key level for rising-edge detection.
    always_comb pause_key_d = pause_key;

    // Pause key history register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pause_key_q <= 1'b0;
        end else begin
            pause_key_q <= pause_key_d;
        end
    end

    assign pause_rise_c = pause_key & ~pause_key_q;
`else
    assign pause_rise_c = 1'b0;
`endif

    assign dir_en_c = (state_q == IDLE) || (state_q == RUN);

    snake_dir_filter u_dir_filter (
        .clk      (clk),
        .rst      (rst),
        .en       (dir_en_c),
        .dir_in   (dir_in),
        .dir_out  (dir_out),
        .accept_c (dir_accept_c)
    );

    // Next-state, sticky-flag, score and handshake logic.
    always_comb begin
        state_d     = state_q;
        move_en_d   = 1'b0;
        count_d     = count_q;
        spawn_req_d = spawn_req_q;
        game_over_d = game_over_q;
        win_d       = win_q;
        s_apple_d   = s_apple_q;
        s_body_d    = s_body_q;
        s_border_d  = s_border_q;

        case (state_q)
            IDLE: begin
                if (dir_accept_c) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (pause_rise_c) begin
                    state_d = PAUSE;
                end else begin
                    // Apple hits are stale while a respawn is outstanding.
                    s_apple_d  = s_apple_q | (hit_apple & ~spawn_req_q);
                    s_body_d   = s_body_q | hit_body;
                    s_border_d = s_border_q | hit_border;
                    if (tick_en) begin
                        if (s_body_d || s_border_d) begin
                            state_d     = OVER;
                            game_over_d = 1'b1;
                        end else if (s_apple_d && (count_q == CNT_W'(WIN_COUNT - 1))) begin
                            count_d = count_q + CNT_W'(1);
                            state_d = WIN;
                            win_d   = 1'b1;
                        end else begin
                            move_en_d = 1'b1;
                            if (s_apple_d) begin
                                count_d     = count_q + CNT_W'(1);
                                spawn_req_d = 1'b1;
                            end
                            s_apple_d  = 1'b0;
                            s_body_d   = 1'b0;
                            s_border_d = 1'b0;
                        end
                    end
                end
            end
            PAUSE: begin
                if (pause_rise_c) begin
                    state_d = RUN;
                end
            end
            default: ;
        endcase

        // Handshake completion; terminal states freeze every output.
        if ((state_q != OVER) && (state_q != WIN) && spawn_req_q && spawn_ack) begin
            spawn_req_d = 1'b0;
        end

        step_size_d = STEP_W'(BASE_STEP) + STEP_W'(count_d >> 1);
    end

    // Controller registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            move_en_q   <= 1'b0;
            step_size_q <= STEP_W'(BASE_STEP);
            count_q     <= '0;
            spawn_req_q <= 1'b0;
            game_over_q <= 1'b0;
            win_q       <= 1'b0;
            s_apple_q   <= 1'b0;
            s_body_q    <= 1'b0;
            s_border_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            move_en_q   <= move_en_d;
            step_size_q <= step_size_d;
            count_q     <= count_d;
            spawn_req_q <= spawn_req_d;
            game_over_q <= game_over_d;
            win_q       <= win_d;
            s_apple_q   <= s_apple_d;
            s_body_q    <= s_body_d;
            s_border_q  <= s_border_d;
        end
    end

    assign move_en     = move_en_q;
    assign step_size   = step_size_q;
    assign apple_count = count_q;
    assign spawn_req   = spawn_req_q;
    assign game_over   = game_over_q;
    assign win         = win_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Testbench for snake_game_ctrl: directed table, hand sequences and random stimulus vs a game model.
module tb_snake_game_ctrl;

    localparam int WIN_COUNT = 16;

    logic       clk = 1'b0;
    logic       rst, tick_en, hit_apple, hit_body, hit_border, spawn_ack;
    logic [3:0] dir_in;
    logic       move_en, spawn_req, game_over, win;
    logic [3:0] dir_out;
    logic [4:0] step_size;
    logic [4:0] apple_count;
`ifdef SNAKE_CTRL_PAUSE_EN
    logic       pause_key = 1'b0;
`endif

    always #5 clk = ~clk;

    snake_game_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .tick_en     (tick_en),
        .dir_in      (dir_in),
        .hit_apple   (hit_apple),
        .hit_body    (hit_body),
        .hit_border  (hit_border),
        .spawn_ack   (spawn_ack),
`ifdef SNAKE_CTRL_PAUSE_EN
        .pause_key   (pause_key),
`endif
        .move_en     (move_en),
        .dir_out     (dir_out),
        .step_size   (step_size),
        .apple_count (apple_count),
        .spawn_req   (spawn_req),
        .game_over   (game_over),
        .win         (win)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Game model: mode 0 waiting, 1 playing, 2 lost, 3 won; heading as index 0..3 (-1 none).
    int m_mode, m_head, m_score;
    bit m_spawn, m_danger, m_apple, m_move;

    function automatic int dir_idx(input logic [3:0] d);
        int cnt = 0;
        int pos = -1;
        for (int i = 0; i < 4; i++) begin
            if (d[i]) begin
                cnt++;
                pos = i;
            end
        end
        return (cnt == 1) ? pos : -1;
    endfunction

    task automatic cmp(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit t, input logic [3:0] d, input bit ha,
                              input bit hb, input bit hbo, input bit ack);
        int  k;
        bit  set_spawn;
        k = dir_idx(d);
        set_spawn = 1'b0;
        if (r) begin
            m_mode = 0; m_head = -1; m_score = 0;
            m_spawn = 0; m_danger = 0; m_apple = 0; m_move = 0;
        end else if (m_mode == 0) begin
            m_move = 0;
            if (k >= 0) begin
                m_head = k;
                m_mode = 1;
            end
        end else if (m_mode == 1) begin
            m_move = 0;
            m_danger = m_danger | hb | hbo;
            if (!m_spawn) m_apple = m_apple | ha;
            if (k >= 0 && k != (m_head + 2) % 4) m_head = k;
            if (t) begin
                if (m_danger) begin
                    m_mode = 2;
                end else if (m_apple && m_score == WIN_COUNT - 1) begin
                    m_score++;
                    m_mode = 3;
                end else begin
                    m_move = 1;
                    if (m_apple) begin
                        m_score++;
                        set_spawn = 1'b1;
                    end
                    m_danger = 0;
                    m_apple = 0;
                end
            end
            if (m_spawn && ack) m_spawn = 0;
            if (set_spawn) m_spawn = 1;
        end
    endtask

    task automatic check_model(input string tag);
        cmp({tag, ".move_en"}, int'(move_en), int'(m_move));
        cmp({tag, ".dir_out"}, int'(dir_out), (m_head < 0) ? 0 : (1 << m_head));
        cmp({tag, ".step_size"}, int'(step_size), 4 + m_score / 2);
        cmp({tag, ".apple_count"}, int'(apple_count), m_score);
        cmp({tag, ".spawn_req"}, int'(spawn_req), int'(m_spawn));
        cmp({tag, ".game_over"}, int'(game_over), int'(m_mode == 2));
        cmp({tag, ".win"}, int'(win), int'(m_mode == 3));
    endtask

    // Apply one cycle of inputs, advance the model, sample after the edge.
    task automatic cycle(input string tag, input bit r, input bit t, input logic [3:0] d,
                         input bit ha, input bit hb, input bit hbo, input bit ack);
        rst = r; tick_en = t; dir_in = d;
        hit_apple = ha; hit_body = hb; hit_border = hbo; spawn_ack = ack;
        @(posedge clk);
        model_step(r, t, d, ha, hb, hbo, ack);
        #1;
        check_model(tag);
    endtask

    typedef struct {
        bit         r, t;
        logic [3:0] d;
        bit         ha, hb, hbo, ack;
        bit         e_move;
        logic [3:0] e_dir;
        int         e_cnt;
        bit         e_spawn, e_over, e_win;
    } vec_t;

    vec_t tbl[14];
    int   high;

    initial begin
        rst = 1'b1; tick_en = 1'b0; dir_in = 4'h0;
        hit_apple = 1'b0; hit_body = 1'b0; hit_border = 1'b0; spawn_ack = 1'b0;

        // Start, three moves, then direction filtering.
        tbl[0]  = '{1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000, 0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1000, 0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000, 0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1000, 0, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1000, 0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000, 0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000, 0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 0, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 0, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 0, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000, 0, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 14; i++) begin
            cycle("tbl", tbl[i].r, tbl[i].t, tbl[i].d, tbl[i].ha, tbl[i].hb, tbl[i].hbo, tbl[i].ack);
            cmp($sformatf("tbl%0d.move_en", i), int'(move_en), int'(tbl[i].e_move));
            cmp($sformatf("tbl%0d.dir_out", i), int'(dir_out), int'(tbl[i].e_dir));
            cmp($sformatf("tbl%0d.apple_count", i), int'(apple_count), tbl[i].e_cnt);
            cmp($sformatf("tbl%0d.step_size", i), int'(step_size), 4);
            cmp($sformatf("tbl%0d.spawn_req", i), int'(spawn_req), int'(tbl[i].e_spawn));
            cmp($sformatf("tbl%0d.game_over", i), int'(game_over), int'(tbl[i].e_over));
            cmp($sformatf("tbl%0d.win", i), int'(win), int'(tbl[i].e_win));
        end

        // Eat once, spawn_req held ten cycles, second tick before ack gives no score.
        cycle("eat", 1, 0, 4'b0000, 0, 0, 0, 0);
        cycle("eat", 0, 0, 4'b1000, 0, 0, 0, 0);
        for (int i = 0; i < 50; i++) cycle("eat", 0, 0, 4'b0000, 1, 0, 0, 0);
        cycle("eat", 0, 1, 4'b0000, 1, 0, 0, 0);
        cmp("eat.count_after_tick", int'(apple_count), 1);
        cmp("eat.move_after_tick", int'(move_en), 1);
        high = int'(spawn_req);
        for (int i = 0; i < 9; i++) begin
            cycle("eat", 0, (i == 4), 4'b0000, 1, 0, 0, 0);
            high += int'(spawn_req);
        end
        cmp("eat.count_second_tick", int'(apple_count), 1);
        cycle("eat", 0, 0, 4'b0000, 0, 0, 0, 1);
        cmp("eat.spawn_after_ack", int'(spawn_req), 0);
        cmp("eat.spawn_high_cycles", high, 10);
        cmp("eat.step_count1", int'(step_size), 4);
        cycle("eat", 0, 0, 4'b0000, 1, 0, 0, 0);
        cycle("eat", 0, 1, 4'b0000, 0, 0, 0, 0);
        cmp("eat.step_count2", int'(step_size), 5);
        cycle("eat", 0, 0, 4'b0000, 0, 0, 0, 1);
        cycle("eat", 0, 0, 4'b0000, 0, 0, 0, 1);

        // Apple and border in the same window: loss wins, score unchanged, then frozen.
        cycle("lose", 1, 0, 4'b0000, 0, 0, 0, 0);
        cycle("lose", 0, 0, 4'b0100, 0, 0, 0, 0);
        cycle("lose", 0, 0, 4'b0000, 1, 0, 0, 0);
        cycle("lose", 0, 0, 4'b0000, 1, 0, 1, 0);
        cycle("lose", 0, 1, 4'b0000, 0, 0, 0, 0);
        cmp("lose.game_over", int'(game_over), 1);
        cmp("lose.count", int'(apple_count), 0);
        cmp("lose.move_en", int'(move_en), 0);
        for (int i = 0; i < 6; i++)
            cycle("lose_hold", 0, 1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        cmp("lose.held", int'(game_over), 1);

        // Climb to the winning apple.
        cycle("win", 1, 0, 4'b0000, 0, 0, 0, 0);
        cycle("win", 0, 0, 4'b1000, 0, 0, 0, 0);
        for (int k = 0; k < 15; k++) begin
            cycle("win", 0, 0, 4'b0000, 1, 0, 0, 0);
            cycle("win", 0, 1, 4'b0000, 0, 0, 0, 0);
            cycle("win", 0, 0, 4'b0000, 0, 0, 0, 1);
            cycle("win", 0, 0, 4'b0000, 0, 0, 0, 0);
        end
        cmp("win.count15", int'(apple_count), 15);
        cmp("win.step15", int'(step_size), 11);
        cycle("win", 0, 0, 4'b0000, 1, 0, 0, 0);
        cycle("win", 0, 1, 4'b0000, 0, 0, 0, 0);
        cmp("win.count16", int'(apple_count), 16);
        cmp("win.win", int'(win), 1);
        cmp("win.spawn_req", int'(spawn_req), 0);
        cmp("win.move_en", int'(move_en), 0);
        cmp("win.step16", int'(step_size), 12);
        cycle("win", 0, 1, 4'b0001, 1, 1, 1, 1);
        cycle("win_rst", 1, 0, 4'b0000, 0, 0, 0, 0);
        cmp("win_rst.count", int'(apple_count), 0);
        cmp("win_rst.win", int'(win), 0);
        cmp("win_rst.step", int'(step_size), 4);

        // Reset in the middle of a respawn handshake.
        cycle("mid", 0, 0, 4'b0001, 0, 0, 0, 0);
        cycle("mid", 0, 0, 4'b0000, 1, 0, 0, 0);
        cycle("mid", 0, 1, 4'b0000, 0, 0, 0, 0);
        cmp("mid.spawn_set", int'(spawn_req), 1);
        cycle("mid", 1, 0, 4'b0000, 0, 0, 0, 0);
        cmp("mid.spawn_cleared", int'(spawn_req), 0);
        cycle("mid", 0, 1, 4'b0000, 0, 0, 0, 1);
        cycle("mid", 0, 1, 4'b0000, 1, 0, 0, 0);
        cmp("mid.idle_no_move", int'(move_en), 0);
        cmp("mid.idle_count", int'(apple_count), 0);

        // Random play against the model.
        for (int i = 0; i < 4000; i++) begin
            logic [3:0] d;
            if ($urandom_range(0, 3) == 0) d = 4'($urandom_range(0, 15));
            else if ($urandom_range(0, 1) == 0) d = 4'b0000;
            else d = 4'(1 << $urandom_range(0, 3));
            cycle("rand", ($urandom_range(0, 299) == 0), ($urandom_range(0, 5) == 0), d,
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 79) == 0),
                  ($urandom_range(0, 79) == 0), ($urandom_range(0, 4) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
